menu_display_scan: RTL and testbench

- Parametrised successor of the main-menu display/keypad block.
- Drives an N-digit multiplexed 7-segment display from a writable message buffer, with static, scroll and blink modes.
- Watches the keypad for a debounced start key and hands control to game mode.
- Sits between the top-level mode controller, the keypad scanner and the on-board segment pins.

---
 rtl/menu_pkg.sv | 30 +++
 rtl/scan_tick_gen.sv | 28 ++
 rtl/menu_display_scan.sv | 137 +++++++++++++
 tb/tb_menu_display_scan.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared constants for the menu, game and score display blocks:
// mode encodings, 7-segment glyphs {g,f,e,d,c,b,a} and the default start key.
package menu_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC       = 2'd0,
    MODE_SCROLL       = 2'd1,
    MODE_BLINK        = 2'd2,
    MODE_SCROLL_BLINK = 2'd3
  } mode_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_R     = 7'b1010000;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_S     = 7'b1101101;

  localparam logic [11:0] START_KEY_DEFAULT = 12'b0000_0000_0001;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV enabled clocks.
// Freezes (and suppresses tick) while enable is low.
module scan_tick_gen #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count_reg;

  assign tick = enable && (count_reg == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/menu_display_scan.sv
// Main-menu display: multiplexes a message buffer onto N 7-segment digits
// with scroll/blink effects, and issues a debounced start pulse from the keypad.
module menu_display_scan
  import menu_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int MSG_LEN       = 16,
  parameter int SCAN_DIV      = 25000,
  parameter int SCROLL_FRAMES = 64,
  parameter int KEY_W         = 12,
  parameter logic [KEY_W-1:0] START_KEY = KEY_W'(START_KEY_DEFAULT),
  parameter int DEBOUNCE      = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic                       msg_we,
  input  logic [$clog2(MSG_LEN)-1:0] msg_addr,
  input  logic [6:0]                 msg_char,
  input  logic                       rearm,
  input  logic [KEY_W-1:0]           key_data,
  output logic                       start_pulse,
  output logic                       menu_active,
  output logic [NUM_DIGITS-1:0]      seg_com,
  output logic [6:0]                 seg_txt
);

  localparam int ADDR_W  = $clog2(MSG_LEN);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int DB_W    = $clog2(DEBOUNCE + 1);

  logic                  tick;
  logic [IDX_W-1:0]      idx_reg;
  logic [ADDR_W-1:0]     offset_reg;
  logic [FRAME_W-1:0]    frame_reg;
  logic                  phase_reg;
  logic [DB_W-1:0]       db_cnt_reg;
  logic                  menu_active_reg;
  logic                  start_pulse_reg;
  logic [NUM_DIGITS-1:0] seg_com_reg;
  logic [6:0]            seg_txt_reg;
  logic [6:0]            msg_buf [MSG_LEN];

  logic                  frame_end;
  logic                  frame_wrap;
  logic [ADDR_W-1:0]     rd_addr;
  logic [NUM_DIGITS-1:0] com_pattern;
  logic                  key_match;
  logic [DB_W-1:0]       db_next;
  logic                  db_done;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  assign frame_end  = tick && (idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap = frame_end && (frame_reg == FRAME_W'(SCROLL_FRAMES - 1));
  assign rd_addr    = offset_reg + ADDR_W'(idx_reg);

  // Digit idx 0 sits on the MSB of the common lines.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_com
    assign com_pattern[gi] = (idx_reg != IDX_W'(NUM_DIGITS - 1 - gi));
  end

  assign key_match = (key_data == START_KEY);
  assign db_next   = !key_match ? '0 :
                     (db_cnt_reg == DB_W'(DEBOUNCE)) ? db_cnt_reg : db_cnt_reg + 1'b1;
  // Fires only on the transition into saturation, so a held key cannot retrigger.
  assign db_done   = tick && menu_active_reg && key_match &&
                     (db_cnt_reg == DB_W'(DEBOUNCE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= '0;
    end else if (msg_we) begin
      msg_buf[msg_addr] <= msg_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg         <= '0;
      offset_reg      <= '0;
      frame_reg       <= '0;
      phase_reg       <= 1'b0;
      db_cnt_reg      <= '0;
      menu_active_reg <= 1'b1;
      start_pulse_reg <= 1'b0;
      seg_com_reg     <= '1;
      seg_txt_reg     <= '0;
    end else begin
      start_pulse_reg <= 1'b0;

      if (tick) begin
        idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
        if (frame_end) frame_reg <= frame_wrap ? '0 : frame_reg + 1'b1;
        if (frame_wrap) begin
          if (mode[0]) offset_reg <= offset_reg + 1'b1;
          if (mode[1]) phase_reg <= ~phase_reg;
          if (mode == MODE_STATIC) begin
            offset_reg <= '0;
            phase_reg  <= 1'b0;
          end
        end
      end

      if (!enable) begin
        seg_com_reg <= '1;
        seg_txt_reg <= '0;
      end else if (tick) begin
        seg_com_reg <= com_pattern;
        seg_txt_reg <= (phase_reg && mode[1]) ? SEG_BLANK : msg_buf[rd_addr];
      end

      if (!menu_active_reg) db_cnt_reg <= '0;
      else if (tick) db_cnt_reg <= db_next;

      if (rearm) begin
        menu_active_reg <= 1'b1;
      end else if (db_done) begin
        menu_active_reg <= 1'b0;
        start_pulse_reg <= 1'b1;
      end
    end
  end

  assign start_pulse = start_pulse_reg;
  assign menu_active = menu_active_reg;
  assign seg_com     = seg_com_reg;
  assign seg_txt     = seg_txt_reg;

endmodule

// File: tb/tb_menu_display_scan.sv
// Bench for menu_display_scan: directed steps plus random writes/keys, every
// cycle compared against a tick-count based reference model.
module tb_menu_display_scan;
  import menu_pkg::*;

  localparam int N   = 8;
  localparam int L   = 16;
  localparam int DIV = 4;
  localparam int F   = 2;
  localparam int D   = 3;
  localparam logic [11:0] SK = 12'h001;

  logic        clk = 1'b0;
  logic        rst, enable, msg_we, rearm;
  logic [1:0]  mode;
  logic [3:0]  msg_addr;
  logic [6:0]  msg_char;
  logic [11:0] key_data;
  logic        start_pulse, menu_active;
  logic [7:0]  seg_com;
  logic [6:0]  seg_txt;

  always #5 clk = ~clk;

  menu_display_scan #(
    .NUM_DIGITS(N), .MSG_LEN(L), .SCAN_DIV(DIV), .SCROLL_FRAMES(F),
    .KEY_W(12), .START_KEY(SK), .DEBOUNCE(D)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .msg_we(msg_we), .msg_addr(msg_addr), .msg_char(msg_char),
    .rearm(rearm), .key_data(key_data),
    .start_pulse(start_pulse), .menu_active(menu_active),
    .seg_com(seg_com), .seg_txt(seg_txt)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  // Reference model state: enabled-cycle and tick counts since reset.
  logic [6:0] m_buf [L];
  int   m_en_cycles, m_ticks, m_offset, m_run;
  bit   m_phase, m_active, m_pulse;
  logic [7:0] m_com;
  logic [6:0] m_txt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit tick;
    int idx;
    tick    = 1'b0;
    m_pulse = 1'b0;
    if (rst) begin
      for (int i = 0; i < L; i++) m_buf[i] = '0;
      m_en_cycles = 0; m_ticks = 0; m_offset = 0; m_run = 0;
      m_phase = 1'b0; m_active = 1'b1; m_com = 8'hFF; m_txt = '0;
      return;
    end
    if (enable) begin
      m_en_cycles++;
      tick = (m_en_cycles % DIV == 0);
    end
    if (!enable) begin
      m_com = 8'hFF;
      m_txt = '0;
    end else if (tick) begin
      idx   = m_ticks % N;
      m_com = 8'hFF ^ (8'h80 >> idx);
      m_txt = (m_phase && mode[1]) ? 7'd0 : m_buf[(m_offset + idx) % L];
    end
    if (tick) begin
      m_ticks++;
      if (m_ticks % (N * F) == 0) begin
        if (mode[0]) m_offset = (m_offset + 1) % L;
        if (mode[1]) m_phase = !m_phase;
        if (mode == 2'd0) begin m_offset = 0; m_phase = 1'b0; end
      end
    end
    if (!m_active) begin
      m_run = 0;
    end else if (tick) begin
      if (key_data == SK) begin
        if (m_run < D) begin
          m_run++;
          if (m_run == D && !rearm) m_pulse = 1'b1;
        end
      end else begin
        m_run = 0;
      end
    end
    if (rearm) m_active = 1'b1;
    else if (m_pulse) m_active = 1'b0;
    if (msg_we) m_buf[msg_addr] = msg_char;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg_com", seg_com, m_com);
    check("seg_txt", seg_txt, m_txt);
    check("menu_active", menu_active, m_active);
    check("start_pulse", start_pulse, m_pulse);
    if (start_pulse === 1'b1) pulses++;
  endtask

  task automatic run_ticks(input int k);
    int target, guard;
    target = m_ticks + k;
    guard  = 0;
    while (m_ticks < target && guard < k * DIV * 2 + 8) begin
      step();
      guard++;
    end
    check("tick_budget", m_ticks, target);
  endtask

  task automatic wait_com(input logic [7:0] value);
    int guard;
    guard = 0;
    while (seg_com !== value && guard < N * DIV * 2) begin
      step();
      guard++;
    end
    check("wait_com", seg_com, value);
  endtask

  logic [6:0] press [8];
  int p0;

  initial begin
    press[0] = SEG_P; press[1] = SEG_R; press[2] = SEG_E; press[3] = SEG_S;
    press[4] = SEG_S; press[5] = SEG_BLANK; press[6] = SEG_0; press[7] = SEG_1;

    rst = 1'b1; enable = 1'b0; mode = 2'd0; msg_we = 1'b0; msg_addr = '0;
    msg_char = '0; rearm = 1'b0; key_data = '0;
    repeat (2) step();
    check("reset_com", seg_com, 8'hFF);
    check("reset_active", menu_active, 1'b1);

    // Load "PRESS 01" plus random tail while the scan starts up.
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < L; i++) begin
      msg_we   = 1'b1;
      msg_addr = 4'(i);
      msg_char = (i < 8) ? press[i] : (i == 8) ? SEG_E : 7'($urandom);
      step();
      if (i == 3) check("first_tick", seg_com, 8'h7F);
    end
    msg_we = 1'b0;

    run_ticks(2 * N);
    wait_com(8'h7F);
    check("static_p", seg_txt, SEG_P);
    wait_com(8'hFE);
    check("static_1", seg_txt, SEG_1);

    // Scroll through a full offset wrap.
    mode = 2'd1;
    run_ticks(N * F * L + 3 * N);

    mode = 2'd2;
    run_ticks(N * F * 4);

    // Scroll+blink with random buffer writes in flight.
    mode = 2'd3;
    for (int i = 0; i < 400; i++) begin
      msg_we   = ($urandom_range(0, 7) == 0);
      msg_addr = 4'($urandom);
      msg_char = 7'($urandom);
      step();
    end
    msg_we = 1'b0;

    enable = 1'b0;
    repeat (7) step();
    check("disabled_com", seg_com, 8'hFF);
    check("disabled_txt", seg_txt, 7'd0);
    enable = 1'b1;
    mode = 2'd0;
    run_ticks(N * F * 2);

    // Start key held: exactly one pulse.
    pulses = 0;
    key_data = SK;
    run_ticks(D);
    step();
    check("one_pulse", pulses, 1);
    check("menu_off", menu_active, 1'b0);
    run_ticks(5);
    check("no_repeat", pulses, 1);

    key_data = '0;
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    check("rearmed", menu_active, 1'b1);
    key_data = SK;
    run_ticks(D - 1);
    key_data = 12'h002;
    run_ticks(4);
    check("short_hold", pulses, 1);
    key_data = 12'h003;
    run_ticks(5);
    check("multi_key", pulses, 1);
    key_data = SK;
    run_ticks(D);
    step();
    check("second_pulse", pulses, 2);

    // Random key activity with occasional rearm.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: key_data = SK;
          1: key_data = SK | 12'h040;
          2: key_data = 12'h002;
          default: key_data = '0;
        endcase
      end
      rearm = ($urandom_range(0, 49) == 0);
      step();
    end
    rearm = 1'b0;

    // Reset in the middle of a debounce.
    key_data = '0;
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    key_data = SK;
    run_ticks(D - 1);
    p0 = pulses;
    rst = 1'b1;
    step();
    check("rst_com", seg_com, 8'hFF);
    check("rst_txt", seg_txt, 7'd0);
    check("rst_active", menu_active, 1'b1);
    check("rst_pulse", start_pulse, 1'b0);
    rst = 1'b0;
    key_data = '0;
    run_ticks(2 * N);
    check("rst_no_pulse", pulses, p0);
    wait_com(8'h7F);
    check("buf_cleared", seg_txt, 7'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
